bus_slave_port: RTL and testbench
=================================

// Module: bus_slave_port
// PURPOSE
//  Slave-side responder of the serial system bus; the other end of the address decoder.
//  Engaged by its decoder select line; bit-serial protocol, LSB first:
//  - accepts the local address and, for writes, the write data;
//  - performs the access on a local memory;
//  - for reads, shifts the read data back to the master.
//  One instance per memory-mapped slave (2K/4K regions).
// PARAMETERS
//  ADDR_W     12  local address width (11 for 2K slave, 12 for 4K)
//  DATA_W     8   data word width
//  READ_WAIT  2   idle cycles between last address bit and first read data bit (0..15)
// PORTS
//  clk      in   1       system clock, all logic on rising edge
//  rst_n    in   1       asynchronous active-low reset
//  sel      in   1       slave select from decoder
//  mode     in   1       1=write, 0=read; sampled with first address bit
//  mvalid   in   1       master bit valid; low = master stall
//  mwdata   in   1       serial address/write-data bit from master
//  srdata   out  1       serial read-data bit to master
//  srvalid  out  1       srdata valid
//  sready   out  1       slave idle, able to start a transfer
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, srdata=0, srvalid=0, sready=1.
//  Reset does not clear memory contents.
//  State machine:
//  - IDLE: sready=1.
//    - sel&&mvalid: capture mwdata as addr[0], latch mode, bit counter=1, go ADDR.
//  - ADDR: each cycle with mvalid=1 shifts mwdata into addr[cnt].
//    - After ADDR_W bits: mode=1 -> WDATA; mode=0 -> RWAIT.
//    - For READ_WAIT=0, mode=0 goes direct to RDATA.
//  - WDATA: each cycle with mvalid=1 shifts one data bit. After DATA_W bits -> WRITE.
//  - WRITE: one cycle; memory write enable asserted. Next cycle -> IDLE.
//  - RWAIT: memory read issued on entry; count READ_WAIT cycles -> RDATA.
//  - RDATA: srvalid=1, srdata=rdata[cnt], one bit per cycle, no stall.
//    - After DATA_W bits -> IDLE.
//  Latency and signalling:
//  - Write: last data bit at cycle N; mem written at N+1; sready=1 at N+2.
//  - Read: last addr bit at cycle N; first data bit at N+1+READ_WAIT.
//  - sready=0 in every state except IDLE. srvalid=0 outside RDATA.
//  - srdata holds 0 when srvalid=0.
//  Boundaries:
//  - sel deasserted in any non-IDLE state: abort next cycle to IDLE, no memory write.
//    srvalid drops immediately on the registered edge.
//  - mvalid=0 in ADDR/WDATA: hold state and counter, no shift. Stall length unbounded.
//  - mvalid ignored in WRITE/RWAIT/RDATA.
//  - sel&&mvalid in the cycle after returning to IDLE starts a new transfer.
//    Back-to-back transfers have exactly one IDLE cycle between them.
//  - Address is the full ADDR_W bits, no wrap logic; memory depth = 2**ADDR_W.
//  - Bit counter width = $clog2(max(ADDR_W,DATA_W)+1); resets to 0 on each phase change.
//  - mode is latched only in IDLE; later changes are ignored.
// STRUCTURE
//  Shared package bus_pkg:
//  - typedef enum slave_state_t {IDLE,ADDR,WDATA,WRITE,RWAIT,RDATA}
//  - constants MODE_READ=1'b0, MODE_WRITE=1'b1.
//  Sub-module slave_bram (ADDR_W, DATA_W):
//  - single-port synchronous memory, registered read, we/addr/wdata/rdata.
//  - No reset on array.
//  FSM, shift registers, counters and output registers live in bus_slave_port.
// TESTING
//  1. Write 8'hA5 to addr 12'h123, then read it back.
//     -> sready high 2 cycles after last write bit;
//     -> read returns bits 1,0,1,0,0,1,0,1 with srvalid=1.
//  2. Write addr 12'hFFF data 8'h3C, stall mvalid=0 for 5 cycles mid-address.
//     -> readback 8'h3C; no shift during stall.
//  3. Drop sel after 6 address bits of a write to 12'h010.
//     -> IDLE next cycle, sready=1.
//     -> later read of 12'h010 returns its prior value.
//  4. Assert rst_n=0 during RDATA bit 3.
//     -> srvalid=0, sready=1 immediately (async).
//     -> after release, a new read of the same address returns correct data.
//  5. Back-to-back write 12'h001/8'h11 then read 12'h001.
//     -> exactly one IDLE cycle between transfers; read returns 8'h11.
//  6. Set READ_WAIT=0, read 12'h002 (holds 8'hF0).
//     -> first srvalid at the cycle after last address bit.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: slave FSM states and mode encoding.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RWAIT,
        RDATA
    } slave_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous memory with registered read; the array has no reset.
module slave_bram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_slave_port.sv
// Slave end of the bit-serial system bus: collects address (and write data) LSB first,
// accesses the local memory, and shifts read data back to the master.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int READ_WAIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    input  logic mode,
    input  logic mvalid,
    input  logic mwdata,
    output logic srdata,
    output logic srvalid,
    output logic sready
);

    // Handshake: a master bit is consumed on a rising edge only when sel && mvalid in
    // IDLE/ADDR/WDATA; read bits flow without back-pressure while srvalid is high.
    localparam int CNT_W = $clog2(max2(max2(ADDR_W, DATA_W), READ_WAIT) + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((READ_WAIT == 0) ? 0 : READ_WAIT - 1);

    slave_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mode_q, mode_d;
    logic              srvalid_q, srvalid_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mode_q    <= MODE_READ;
            srvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mode_q    <= mode_d;
            srvalid_q <= srvalid_d;
        end
    end

    // Bits enter at the MSB and shift down, so the first (LSB) bit ends up at index 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mode_d  = mode_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && mvalid) begin
                    addr_d  = {mwdata, addr_q[ADDR_W-1:1]};
                    mode_d  = mode;
                    cnt_d   = CNT_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (mvalid) begin
                    addr_d = {mwdata, addr_q[ADDR_W-1:1]};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (mode_q == MODE_WRITE)  state_d = WDATA;
                        else if (READ_WAIT == 0)   state_d = RDATA;
                        else                       state_d = RWAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WDATA: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (mvalid) begin
                    wdata_d = {mwdata, wdata_q[DATA_W-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                // A select dropped in this cycle aborts the access before it lands.
                mem_we  = sel;
                state_d = IDLE;
            end
            RWAIT, RDATA: begin
                if (!sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == ((state_q == RWAIT) ? WAIT_LAST : DATA_LAST)) begin
                    cnt_d   = '0;
                    state_d = (state_q == RWAIT) ? RDATA : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        srvalid_d = (state_d == RDATA);
    end

    // Memory is addressed with the next-state address so the read launches on the
    // same edge that takes the last address bit (needed when READ_WAIT is 0).
    slave_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_d),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) rd_bit = mem_rdata[i];
        end
    end

    assign srvalid = srvalid_q;
    assign srdata  = srvalid_q & rd_bit;
    assign sready  = (state_q == IDLE);

endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: two instances (READ_WAIT 2 and 0) driven by serial bus tasks.
module tb_bus_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel2, sel0, mode, mvalid, mwdata;
    logic srdata2, srvalid2, sready2;
    logic srdata0, srvalid0, sready0;

    bus_slave_port #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel2),
        .mode    (mode),
        .mvalid  (mvalid),
        .mwdata  (mwdata),
        .srdata  (srdata2),
        .srvalid (srvalid2),
        .sready  (sready2)
    );

    bus_slave_port #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(0)) dut_rw0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel0),
        .mode    (mode),
        .mvalid  (mvalid),
        .mwdata  (mwdata),
        .srdata  (srdata0),
        .srvalid (srvalid0),
        .sready  (sready0)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [2][0:(1<<AW)-1];
    logic [AW-1:0] wa0[$];
    logic [AW-1:0] wa1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic rbit();
        return 1'($urandom & 1);
    endfunction

    function automatic int rw_of(input int inst);
        return (inst == 0) ? 2 : 0;
    endfunction

    function automatic logic o_srvalid(input int inst);
        return (inst == 0) ? srvalid2 : srvalid0;
    endfunction

    function automatic logic o_srdata(input int inst);
        return (inst == 0) ? srdata2 : srdata0;
    endfunction

    function automatic logic o_sready(input int inst);
        return (inst == 0) ? sready2 : sready0;
    endfunction

    // ---------------- driver tasks (drive and sample on the falling edge) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sel2 = 1'b0; sel0 = 1'b0; mvalid = 1'b0; mwdata = rbit(); mode = rbit();
            check("idle_sready2", sready2, 1);
            check("idle_sready0", sready0, 1);
        end
    endtask

    task automatic stall(input int inst, input int n);
        repeat (n) begin
            @(negedge clk);
            check("stall_sready", o_sready(inst), 0);
            check("stall_srvalid", o_srvalid(inst), 0);
            mvalid = 1'b0; mwdata = rbit(); mode = rbit();
        end
    endtask

    task automatic start_addr(input int inst, input logic md, input logic [AW-1:0] a,
                              input int nbits, input int max_stall, input int fix_at,
                              input int fix_len);
        @(negedge clk);
        check("start_sready", o_sready(inst), 1);
        sel2 = (inst == 0); sel0 = (inst == 1);
        mvalid = 1'b1; mode = md; mwdata = a[0];
        for (int i = 1; i < nbits; i++) begin
            if (i == fix_at) stall(inst, fix_len);
            if (max_stall > 0) stall(inst, $urandom_range(max_stall, 0));
            @(negedge clk);
            mvalid = 1'b1; mwdata = a[i]; mode = rbit();
        end
    endtask

    task automatic bus_write(input int inst, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int max_stall, input int fix_at, input int fix_len);
        start_addr(inst, 1'b1, a, AW, max_stall, fix_at, fix_len);
        for (int i = 0; i < DW; i++) begin
            if (max_stall > 0) stall(inst, $urandom_range(max_stall, 0));
            @(negedge clk);
            mvalid = 1'b1; mwdata = d[i]; mode = rbit();
        end
        @(negedge clk);
        mvalid = rbit(); mwdata = rbit();
        check("write_cycle_sready", o_sready(inst), 0);
        model[inst][a] = d;
        if (inst == 0) wa0.push_back(a); else wa1.push_back(a);
    endtask

    task automatic bus_read(input int inst, input logic [AW-1:0] a, input int max_stall,
                            input int rst_at);
        logic [DW-1:0] exp;
        logic [DW-1:0] got;
        got = '0;
        exp_q.push_back(model[inst][a]);
        start_addr(inst, 1'b0, a, AW, max_stall, -1, 0);
        for (int k = 0; k < rw_of(inst); k++) begin
            @(negedge clk);
            mvalid = rbit(); mwdata = rbit(); mode = rbit();
            check("rwait_srvalid", o_srvalid(inst), 0);
            check("rwait_srdata", o_srdata(inst), 0);
            check("rwait_sready", o_sready(inst), 0);
        end
        exp = exp_q.pop_front();
        for (int b = 0; b < DW; b++) begin
            @(negedge clk);
            mvalid = rbit(); mwdata = rbit(); mode = rbit();
            check("rdata_srvalid", o_srvalid(inst), 1);
            check("rdata_bit", o_srdata(inst), exp[b]);
            check("rdata_sready", o_sready(inst), 0);
            got[b] = o_srdata(inst);
            if (b == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_srvalid", o_srvalid(inst), 0);
                check("rst_srdata", o_srdata(inst), 0);
                check("rst_sready", o_sready(inst), 1);
                @(negedge clk);
                rst_n = 1'b1; sel2 = 1'b0; sel0 = 1'b0; mvalid = 1'b0;
                return;
            end
        end
        check("read_word", got, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int inst;
        sel2 = 1'b0; sel0 = 1'b0; mode = 1'b0; mvalid = 1'b0; mwdata = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_sready", o_sready(i), 1);
            check("reset_srvalid", o_srvalid(i), 0);
            check("reset_srdata", o_srdata(i), 0);
        end
        rst_n = 1'b1;
        idle(1);

        // Write then read back, fixed pattern.
        bus_write(0, 12'h123, 8'hA5, 0, -1, 0);
        idle(1);
        bus_read(0, 12'h123, 0, -1);
        check("t1_value", model[0][12'h123], 8'hA5);
        idle(1);

        // Five-cycle stall in the middle of the address.
        bus_write(0, 12'hFFF, 8'h3C, 0, 6, 5);
        idle(2);
        bus_read(0, 12'hFFF, 0, -1);
        idle(1);

        // Select dropped after six address bits of a write: no write must happen.
        bus_write(0, 12'h010, 8'h5A, 1, -1, 0);
        idle(1);
        start_addr(0, 1'b1, 12'h010, 6, 0, -1, 0);
        @(negedge clk);
        sel2 = 1'b0; mvalid = rbit(); mwdata = rbit();
        check("abort_sready_before", sready2, 0);
        @(negedge clk);
        mvalid = 1'b0;
        check("abort_sready_after", sready2, 1);
        idle(2);
        bus_read(0, 12'h010, 1, -1);
        idle(1);

        // Asynchronous reset during read bit 3, then a clean re-read.
        bus_write(0, 12'h2A0, 8'hC6, 0, -1, 0);
        idle(1);
        bus_read(0, 12'h2A0, 0, 3);
        idle(1);
        bus_read(0, 12'h2A0, 0, -1);

        // Back-to-back transfers with a single idle cycle in between.
        bus_write(0, 12'h001, 8'h11, 0, -1, 0);
        bus_read(0, 12'h001, 0, -1);
        bus_read(0, 12'h001, 0, -1);
        idle(1);

        // Zero read-wait instance.
        bus_write(1, 12'h002, 8'hF0, 0, -1, 0);
        bus_read(1, 12'h002, 0, -1);
        idle(1);

        // Randomized traffic on both instances.
        for (int it = 0; it < 30; it++) begin
            inst = $urandom_range(1, 0);
            if ($urandom_range(1, 0) == 0 || (inst == 0 ? wa0.size() : wa1.size()) == 0) begin
                a = AW'($urandom);
                d = DW'($urandom);
                bus_write(inst, a, d, 2, -1, 0);
            end else begin
                a = (inst == 0) ? wa0[$urandom_range(wa0.size() - 1, 0)]
                                : wa1[$urandom_range(wa1.size() - 1, 0)];
                bus_read(inst, a, 2, -1);
            end
            if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
